// File: rtl/mem_stage_pkg.sv
`default_nettype none
// =====================================================================
// mem_stage_pkg : state encoding, timeout and widths for the MEM stage
// Rev 1.0
// =====================================================================
package mem_stage_pkg;

  localparam int         c_DATA_W  = 16;
  localparam int         c_REG_W   = 3;
  localparam int         c_CNT_W   = 4;
  localparam logic [3:0] c_TIMEOUT = 4'd15;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_fsm.sv
`default_nettype none
// =====================================================================
// mem_ctrl_fsm : data-memory request/wait controller, Stall and Err
// Rev 1.0
// =====================================================================
module mem_ctrl_fsm
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_op_i,
  input  logic rd_i,
  input  logic wr_i,
  input  logic addr_lsb_i,
  input  logic mem_Done_i,
  input  logic mem_Stall_i,
  output logic mem_Rd_o,
  output logic mem_Wr_o,
  output logic stall_o,
  output logic zero_data_o,
  output logic err_o
);

  state_e             state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               w_illegal, w_req, w_done, w_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    w_req     = 1'b0;
    w_done    = 1'b0;
    w_zero    = 1'b0;
    w_illegal = mem_op_i & ((rd_i & wr_i) | addr_lsb_i);
    case (state_q)
      ST_IDLE: begin
        if (w_illegal) begin
          w_done = 1'b1;
          w_zero = 1'b1;
          err_d  = 1'b1;
        end else if (mem_op_i && !mem_Stall_i) begin
          w_req = 1'b1;
          if (mem_Done_i) begin
            w_done = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = '0;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_Done_i) begin
          w_done  = 1'b1;
          state_d = ST_IDLE;
        // counter starts at 0 on the first BUSY cycle, so 14 marks the 15th
        end else if (cnt_q == c_TIMEOUT - 4'd1) begin
          w_done  = 1'b1;
          w_zero  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_Rd_o    = w_req & rd_i;
  assign mem_Wr_o    = w_req & wr_i;
  assign stall_o     = mem_op_i & ~w_done;
  assign zero_data_o = w_zero;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// =====================================================================
// mem_stage : EX/MEM and MEM/WB pipeline registers around the memory FSM
// Rev 1.0
// =====================================================================
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [c_DATA_W-1:0] ex_Result,
  input  logic [c_DATA_W-1:0] ex_StData,
  input  logic                ex_valid,
  input  logic                ex_MemRead,
  input  logic                ex_MemWrite,
  input  logic                ex_RegWrite,
  input  logic                ex_Halt,
  input  logic [c_REG_W-1:0]  ex_WrReg,
  output logic [c_DATA_W-1:0] mem_Addr,
  output logic [c_DATA_W-1:0] mem_DataIn,
  output logic                mem_Rd,
  output logic                mem_Wr,
  input  logic [c_DATA_W-1:0] mem_DataOut,
  input  logic                mem_Done,
  input  logic                mem_Stall,
  output logic [c_DATA_W-1:0] PipeEM_Result,
  output logic [c_DATA_W-1:0] PipeMW_Result,
  output logic [c_REG_W-1:0]  wb_WrReg,
  output logic                wb_RegWrite,
  output logic                wb_valid,
  output logic                wb_Halt,
  output logic                Stall,
  output logic                Err
);

  logic                em_valid_q, em_MemRead_q, em_MemWrite_q, em_RegWrite_q, em_Halt_q;
  logic [c_DATA_W-1:0] em_Result_q, em_StData_q;
  logic [c_REG_W-1:0]  em_WrReg_q;
  logic [c_DATA_W-1:0] mw_data_q;
  logic [c_REG_W-1:0]  mw_WrReg_q;
  logic                mw_RegWrite_q, mw_valid_q, mw_Halt_q;
  logic                w_mem_op, w_zero_data;
  logic [c_DATA_W-1:0] w_wb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_valid_q    <= 1'b0;
      em_MemRead_q  <= 1'b0;
      em_MemWrite_q <= 1'b0;
      em_RegWrite_q <= 1'b0;
      em_Halt_q     <= 1'b0;
      em_Result_q   <= '0;
      em_StData_q   <= '0;
      em_WrReg_q    <= '0;
    end else if (!Stall) begin
      em_valid_q    <= ex_valid;
      em_MemRead_q  <= ex_MemRead;
      em_MemWrite_q <= ex_MemWrite;
      em_RegWrite_q <= ex_RegWrite;
      em_Halt_q     <= ex_Halt;
      em_Result_q   <= ex_Result;
      em_StData_q   <= ex_StData;
      em_WrReg_q    <= ex_WrReg;
    end
  end

  assign w_mem_op = em_valid_q & (em_MemRead_q | em_MemWrite_q);

  mem_ctrl_fsm u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .mem_op_i    (w_mem_op),
    .rd_i        (em_MemRead_q),
    .wr_i        (em_MemWrite_q),
    .addr_lsb_i  (em_Result_q[0]),
    .mem_Done_i  (mem_Done),
    .mem_Stall_i (mem_Stall),
    .mem_Rd_o    (mem_Rd),
    .mem_Wr_o    (mem_Wr),
    .stall_o     (Stall),
    .zero_data_o (w_zero_data),
    .err_o       (Err)
  );

  always_comb begin
    w_wb_data = em_Result_q;
    if (w_zero_data) begin
      w_wb_data = '0;
    end else if (w_mem_op && em_MemRead_q) begin
      w_wb_data = mem_DataOut;
    end
  end

  // Stalled edges push a bubble; data and register index stay put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mw_data_q     <= '0;
      mw_WrReg_q    <= '0;
      mw_RegWrite_q <= 1'b0;
      mw_valid_q    <= 1'b0;
      mw_Halt_q     <= 1'b0;
    end else if (Stall) begin
      mw_RegWrite_q <= 1'b0;
      mw_valid_q    <= 1'b0;
      mw_Halt_q     <= 1'b0;
    end else begin
      mw_data_q     <= w_wb_data;
      mw_WrReg_q    <= em_WrReg_q;
      mw_RegWrite_q <= em_RegWrite_q & ~em_MemWrite_q;
      mw_valid_q    <= em_valid_q;
      mw_Halt_q     <= em_Halt_q;
    end
  end

  assign mem_Addr      = em_Result_q;
  assign mem_DataIn    = em_StData_q;
  assign PipeEM_Result = em_Result_q;
  assign PipeMW_Result = mw_data_q;
  assign wb_WrReg      = mw_WrReg_q;
  assign wb_RegWrite   = mw_RegWrite_q;
  assign wb_valid      = mw_valid_q;
  assign wb_Halt       = mw_Halt_q;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have `clk`, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have `rst`, input, 1, an asynchronous active-high reset.
REQ-003 The block SHALL have `ex_Result`, input, 16, the execute-stage ALU/set/btr result, used as the memory address or the writeback data.
REQ-004 The block SHALL have `ex_StData`, input, 16, the forwarded store data from execute.
REQ-005 The block SHALL have the following 1-bit inputs: `ex_valid`, `ex_MemRead`, `ex_MemWrite`, `ex_RegWrite`, `ex_Halt`; each is the execute-stage control for the current instruction.
REQ-006 The block SHALL have `ex_WrReg`, input, 3, the destination register.
REQ-007 The block SHALL have the following outputs to data memory: `mem_Addr` (16), `mem_DataIn` (16), `mem_Rd` (1), `mem_Wr` (1).
REQ-008 The block SHALL have the following inputs from data memory: `mem_DataOut` (16), `mem_Done` (1), `mem_Stall` (1, bank busy and request refused).
REQ-009 The block SHALL have `PipeEM_Result`, output, 16, the registered EX/MEM result, forwarded to execute.
REQ-010 The block SHALL have `PipeMW_Result`, output, 16, the registered MEM/WB data, forwarded to execute.
REQ-011 The block SHALL have the following writeback outputs: `wb_WrReg` (3), `wb_RegWrite` (1), `wb_valid` (1), `wb_Halt` (1).
REQ-012 The block SHALL have `Stall`, output, 1, combinational; when high, upstream stages hold.
REQ-013 The block SHALL have `Err`, output, 1, sticky error.

Function
REQ-014 The EX/MEM register SHALL load all `ex_*` inputs on an edge where `Stall`=0, and SHALL hold them otherwise.
REQ-015 An EX/MEM entry with valid=1 and MemRead or MemWrite set SHALL be a "mem op"; every other entry SHALL be a "pass op".
REQ-016 `PipeEM_Result` SHALL equal the registered `ex_Result`.
REQ-017 The FSM SHALL have two states, IDLE and BUSY, plus a 4-bit wait counter.
REQ-018 In IDLE with a mem op and `mem_Stall`=0, the block SHALL drive `mem_Rd`/`mem_Wr` high for exactly this cycle, with `mem_Addr`=EM result and `mem_DataIn`=EM store data.
REQ-019 In IDLE, if `mem_Done`=1 in the same cycle as the request, the access SHALL complete (0-wait hit).
REQ-020 In IDLE, if `mem_Done`=0 after the request, the FSM SHALL go to BUSY and clear the counter.
REQ-021 In IDLE with a mem op and `mem_Stall`=1, the block SHALL issue no request, stay in IDLE, and retry next cycle.
REQ-022 In BUSY, `mem_Rd`/`mem_Wr` SHALL be low and the counter SHALL increment each cycle.
REQ-023 In BUSY, `mem_Done`=1 SHALL complete the access and return the FSM to IDLE.
REQ-024 `Stall` SHALL equal mem op AND NOT completion-this-cycle, so it is low on the completing cycle and the next instruction loads.
REQ-025 On a completion or pass-op edge, MEM/WB SHALL load WrReg, RegWrite, valid, and Halt from EM, with data = `mem_DataOut` for a read or the EM result otherwise.
REQ-026 On a stall edge, MEM/WB SHALL load a bubble: valid=0, RegWrite=0, Halt=0, data held.
REQ-027 `PipeMW_Result` SHALL equal the registered MEM/WB data.
REQ-028 On a store, MEM/WB SHALL carry `wb_RegWrite`=0 regardless of `ex_RegWrite`.
REQ-029 A mem op with both MemRead and MemWrite set, or with `ex_Result[0]`=1 (unaligned), SHALL set `Err`, issue no request, and complete immediately with data 0.
REQ-030 A BUSY residency reaching 15 cycles SHALL set `Err`, force completion with data 0, and return the FSM to IDLE.
REQ-031 `Err` SHALL stay high until reset.
REQ-032 `mem_Rd` and `mem_Wr` SHALL never be high together and SHALL never be high in BUSY.

Reset
REQ-033 While `rst` is high, the block SHALL clear all EM and MW registers to 0, set the FSM to IDLE, clear the counter, and set `Err`=0.
REQ-034 While `rst` is high, `mem_Rd`, `mem_Wr`, `Stall`, `wb_valid`, and `wb_RegWrite` SHALL be 0.
REQ-035 A reset asserted while in BUSY SHALL abandon the access, and any later `mem_Done` SHALL be ignored while in IDLE without a request.

Structure
REQ-036 The shared package `mem_stage_pkg` SHALL hold the FSM state encoding, the timeout constant (15), and the width constants (16 data, 3 register).
REQ-037 The block SHALL contain one sub-module, `mem_ctrl_fsm`, holding the state, counter, request, Stall and Err logic; the pipeline registers SHALL be in the top level.

Verification
REQ-038 Load with addr 0x0010, `mem_Done` in the request cycle, `mem_DataOut`=0xBEEF -> one `mem_Rd` pulse, Stall never high, `wb_valid`=1, `PipeMW_Result`=0xBEEF next edge.
REQ-039 Store 0x1234 to 0x0020 with Done 3 cycles later -> `mem_Wr` pulses once, Stall high for 3 cycles, 3 bubbles in MW, then `wb_RegWrite`=0.
REQ-040 `mem_Stall`=1 for 2 cycles on a load -> no `mem_Rd` for 2 cycles, request on the 3rd, EM contents held throughout.
REQ-041 Back-to-back ADD result 0x0005 then a load -> `PipeEM_Result`=0x0005 for one cycle, ADD writes back while the load issues.
REQ-042 Load to 0x0011 -> `Err`=1, no `mem_Rd`, MW data 0; `Err` remains 1 after 10 further cycles.
REQ-043 BUSY with no Done -> `Err` set at cycle 15, Stall drops; reset mid-BUSY -> IDLE, all outputs 0.
